// File: rtl/booth_pkg.sv
// Shared widths, FSM state type and the full-adder cell for the Booth
// product accumulator.
package booth_pkg;

   localparam int N     = 8;
   localparam int LEN_W = 4;
   localparam int ACC_W = 2*N + LEN_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // One full-adder cell: returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
      logic s;
      logic co;
      s  = a ^ b ^ ci;
      co = (a & b) | (ci & (a ^ b));
      return {co, s};
   endfunction

endpackage

// File: rtl/booth_acc_if.sv
// Job request, product stream and result handshake of the accumulator.
interface booth_acc_if #(
   parameter int N     = booth_pkg::N,
   parameter int LEN_W = booth_pkg::LEN_W
);
   localparam int ACC_W = 2*N + LEN_W;

   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic [2*N-1:0]   in_prod;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic             busy;

   modport master (
      output start, len, in_valid, in_prod, out_ready,
      input  in_ready, out_valid, out_sum, busy
   );

   modport slave (
      input  start, len, in_valid, in_prod, out_ready,
      output in_ready, out_valid, out_sum, busy
   );

endinterface

// File: rtl/booth_acc_add.sv
// Ripple-carry adder chained from full-adder cells; carry-out is dropped
// because the accumulator is sized so it can never overflow.
module booth_acc_add #(
   parameter int W = booth_pkg::ACC_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);
   import booth_pkg::*;

   // Carry ripples bit by bit through the full-adder cells.
   always_comb begin
      logic       carry;
      logic [1:0] fa;
      sum   = '0;
      carry = 1'b0;
      for (int i = 0; i < W; i++) begin
         fa     = full_add(a[i], b[i], carry);
         sum[i] = fa[0];
         carry  = fa[1];
      end
   end

endmodule

// File: rtl/booth_acc.sv
// Sums a counted burst of unsigned products from the Booth multiplier and
// holds the total until the downstream consumer takes it.
//
// state | meaning
// IDLE  | waiting for start; len latched with start
// ACCUM | accepting products, counter tracks beats still owed
// DONE  | result presented on out_sum until out handshake
module booth_acc #(
   parameter int N     = booth_pkg::N,
   parameter int LEN_W = booth_pkg::LEN_W
) (
   input logic        clk,
   input logic        rst,
   booth_acc_if.slave bus
);
   import booth_pkg::*;

   localparam int ACC_W = 2*N + LEN_W;

   state_t           state_q;
   state_t           state_nx;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_sum;
   logic [ACC_W-1:0] prod_ext;
   logic [LEN_W-1:0] cnt_q;
   logic             in_rdy;
   logic             beat;
   logic             acc_clr;
   logic             cnt_load;

   // in_ready comes straight from the state register, never from in_valid.
   assign in_rdy   = (state_q == ACCUM);
   assign beat     = bus.in_valid & in_rdy;
   assign prod_ext = {{LEN_W{1'b0}}, bus.in_prod};

   booth_acc_add #(.W(ACC_W)) u_add (
      .a   (acc_q),
      .b   (prod_ext),
      .sum (acc_sum)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_nx;
   end

   // Next-state and datapath control.
   always_comb begin
      state_nx = state_q;
      acc_clr  = 1'b0;
      cnt_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_clr = 1'b1;
               if (bus.len != '0) begin
                  cnt_load = 1'b1;
                  state_nx = ACCUM;
               end else begin
                  state_nx = DONE;
               end
            end
         end
         ACCUM: begin
            if (beat && (cnt_q == LEN_W'(1))) state_nx = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Accumulator and beat down-counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         if (acc_clr)   acc_q <= '0;
         else if (beat) acc_q <= acc_sum;
         if (cnt_load)  cnt_q <= bus.len;
         else if (beat) cnt_q <= cnt_q - LEN_W'(1);
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_sum   = acc_q;

endmodule

// File: tb/tb_booth_acc.sv
// Randomised and directed jobs against a plain-arithmetic sum model; results
// are checked by a monitor popping a scoreboard on each output handshake.
module tb_booth_acc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   longint sb[$];

   always #5 clk = ~clk;

   booth_acc_if bus ();

   booth_acc dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic void chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // gap_mode: 0 no gaps, 1 one idle cycle before the second beat, 2 random gaps.
   // poke: pulse start with a different len during ACCUM and DONE.
   task automatic run_job(input int l, input int prods[$], input int gap_mode,
                          input int bp, input bit poke);
      longint exp;
      exp = 0;
      foreach (prods[i]) exp += longint'(prods[i]);
      sb.push_back(exp);
      bus.start = 1'b1;
      bus.len   = 4'(l);
      step();
      bus.start = 1'b0;
      chk("busy_after_start", longint'(bus.busy), 1);
      chk("in_ready_after_start", longint'(bus.in_ready), longint'(l != 0));
      for (int i = 0; i < l; i++) begin
         int g;
         g = 0;
         while ((gap_mode == 1 && i == 1 && g < 1) ||
                (gap_mode == 2 && g < 3 && $urandom_range(0, 3) == 0)) begin
            bus.in_valid = 1'b0;
            step();
            g++;
            chk("in_ready_in_gap", longint'(bus.in_ready), 1);
         end
         bus.in_valid = 1'b1;
         bus.in_prod  = 16'(prods[i]);
         if (poke && i == 0) begin
            bus.start = 1'b1;
            bus.len   = 4'd7;
         end
         step();
         bus.in_valid = 1'b0;
         bus.start    = 1'b0;
         chk("in_ready_after_beat", longint'(bus.in_ready), longint'(i != l - 1));
         chk("busy_in_job", longint'(bus.busy), 1);
      end
      chk("out_valid_rise", longint'(bus.out_valid), 1);
      for (int k = 0; k < bp; k++) begin
         bus.out_ready = 1'b0;
         if (poke) begin
            bus.start = 1'b1;
            bus.len   = 4'd5;
         end
         step();
         chk("out_valid_held", longint'(bus.out_valid), 1);
      end
      bus.out_ready = 1'b1;
      if (poke) begin
         bus.start = 1'b1;
         bus.len   = 4'd5;
      end
      step();
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      chk("idle_busy_after_hs", longint'(bus.busy), 0);
      chk("idle_valid_after_hs", longint'(bus.out_valid), 0);
   endtask

   // Monitor: result checking and stability under backpressure.
   initial begin
      logic        held;
      logic [19:0] hv;
      held = 1'b0;
      hv   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else if (bus.out_valid) begin
            if (held) chk("out_sum_stable", longint'(bus.out_sum), longint'(hv));
            if (bus.out_ready) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_output: got sum %0d with no job pending", bus.out_sum);
               end else begin
                  chk("out_sum", longint'(bus.out_sum), sb.pop_front());
               end
               held = 1'b0;
            end else begin
               held = 1'b1;
               hv   = bus.out_sum;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int q[$];
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.in_valid  = 1'b0;
      bus.in_prod   = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      step(); step(); step();
      chk("rst_busy", longint'(bus.busy), 0);
      chk("rst_in_ready", longint'(bus.in_ready), 0);
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_out_sum", longint'(bus.out_sum), 0);
      rst = 1'b0;
      step();

      // Basic job.
      q = '{100, 200, 300};
      run_job(3, q, 0, 0, 1'b0);
      step();
      // Gap on input and four cycles of backpressure.
      q = '{5, 7};
      run_job(2, q, 1, 4, 1'b0);
      step();
      // Zero length.
      q = {};
      run_job(0, q, 0, 1, 1'b0);
      step();
      // Widest sum.
      q = {};
      for (int i = 0; i < 15; i++) q.push_back(65025);
      run_job(15, q, 0, 0, 1'b0);
      step();
      // Stray starts during ACCUM, DONE and the output handshake.
      q = '{11, 22, 33};
      run_job(3, q, 0, 2, 1'b1);
      step();
      chk("no_extra_job", longint'(bus.busy), 0);

      // Reset mid-job abandons the partial sum.
      sb.push_back(0);
      bus.start = 1'b1;
      bus.len   = 4'd4;
      step();
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_prod  = 16'd50;
      step();
      bus.in_prod  = 16'd60;
      step();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      void'(sb.pop_back());
      chk("midjob_rst_busy", longint'(bus.busy), 0);
      chk("midjob_rst_out_valid", longint'(bus.out_valid), 0);
      chk("midjob_rst_out_sum", longint'(bus.out_sum), 0);
      chk("midjob_rst_in_ready", longint'(bus.in_ready), 0);
      q = '{9};
      run_job(1, q, 0, 0, 1'b0);
      step();

      // Reset wins over a simultaneous start.
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.len   = 4'd3;
      step();
      rst       = 1'b0;
      bus.start = 1'b0;
      chk("rst_over_start", longint'(bus.busy), 0);
      step();

      // Randomised jobs.
      for (int j = 0; j < 30; j++) begin
         int l;
         l = int'($urandom_range(0, 15));
         q = {};
         for (int i = 0; i < l; i++) q.push_back(int'($urandom_range(0, 65535)));
         run_job(l, q, 2, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) step();
      end

      step(); step();
      chk("scoreboard_drained", longint'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
